ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of the in-order pipeline with the EX/MEM register.
//
// Single-cycle ALU ops (ADD, SUB, logic, compares, shifts) are written into
// EX/MEM at the next rising edge. MUL (and, when the divider is built, DIVU /
// REMU) runs on a small iterative FSM: the op is accepted with Stall raised
// combinationally, iterates for 32 cycles and is written into EX/MEM from the
// DONE state. Every edge taken with Stall high writes a bubble (MemValid=0).
//
// Build option:
//   EX_DIV_EN  -- when defined, AluOp 9/A run on a restoring unsigned divider
//                 (DIV state). When undefined they are single-cycle ops that
//                 return 0 and never stall.
//
// Ports:
//   clk                          rising-edge clock
//   rst                          asynchronous active-low reset
//   ExValid                      ID/EX holds a live instruction
//   ExWb[3:0]                    writeback control, bit2 = RegDst
//   ExM[1:0]                     memory control, passed through
//   ExEx[4:0]                    bit4 = ALUSrc, bits3:0 = AluOp
//   ExReadD1/ExReadD2/ExAdr      operand A, register B, sign-extended immediate
//   ExRt/ExRd/ExRs               register numbers (ExRs not used here)
//   Stall                        holds PC, IF/ID and ID/EX while high
//   MemWb/MemM/MemAluRes/MemWriteD/MemDst/MemValid   EX/MEM register
// ----------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ExValid,
  input  logic [3:0]  ExWb,
  input  logic [1:0]  ExM,
  input  logic [4:0]  ExEx,
  input  logic [31:0] ExReadD1,
  input  logic [31:0] ExReadD2,
  input  logic [31:0] ExAdr,
  input  logic [4:0]  ExRt,
  input  logic [4:0]  ExRd,
  input  logic [4:0]  ExRs,
  output logic        Stall,
  output logic [3:0]  MemWb,
  output logic [1:0]  MemM,
  output logic [31:0] MemAluRes,
  output logic [31:0] MemWriteD,
  output logic [4:0]  MemDst,
  output logic        MemValid
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIVU = 4'h9;
  localparam logic [3:0] OP_REMU = 4'hA;
  localparam logic [3:0] OP_SLL  = 4'hB;
  localparam logic [3:0] OP_SRL  = 4'hC;
  localparam logic [3:0] OP_SRA  = 4'hD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef EX_DIV_EN
    DIV  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] op_a;      // MUL: shifted multiplicand; DIV: dividend -> quotient
  logic [31:0] op_b;      // MUL: shifted multiplier;   DIV: divisor
  logic [31:0] acc;       // MUL: partial product;      DIV: partial remainder

  // ID/EX fields captured at accept, replayed into EX/MEM from DONE.
  logic [3:0]  hold_wb;
  logic [1:0]  hold_m;
  logic [31:0] hold_wd;
  logic [4:0]  hold_dst;
  logic        hold_quot; // result is the quotient (DIVU) rather than acc

  logic [3:0]  alu_op;
  logic [31:0] alu_b;
  logic [4:0]  dst_sel;
  logic        is_multi;
  logic        start;
  logic [31:0] alu_res;

  assign alu_op  = ExEx[3:0];
  assign alu_b   = ExEx[4] ? ExAdr : ExReadD2;
  assign dst_sel = ExWb[2] ? ExRd : ExRt;

  // The source register number is only needed by forwarding/hazard logic
  // elsewhere; fold it into a sink so it is visibly consumed.
  logic unused_rs;
  assign unused_rs = ^ExRs;

`ifdef EX_DIV_EN
  assign is_multi = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
`else
  assign is_multi = (alu_op == OP_MUL);
`endif

  assign start = (state == IDLE) && ExValid && is_multi;

  // Stall is combinational so the accept cycle itself already freezes the
  // upstream registers; reset overrides everything.
  always_comb begin
    Stall = 1'b0;
    if (rst) begin
      Stall = start || (state == MUL)
`ifdef EX_DIV_EN
              || (state == DIV)
`endif
              ;
    end
  end

  // Single-cycle ALU. Multi-cycle opcodes yield 0 here: they are either
  // handled by the FSM or, without the divider, defined to return 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    alu_res = 32'h0;
    unique case (alu_op)
      OP_ADD:  alu_res = ExReadD1 + alu_b;
      OP_SUB:  alu_res = ExReadD1 - alu_b;
      OP_AND:  alu_res = ExReadD1 & alu_b;
      OP_OR:   alu_res = ExReadD1 | alu_b;
      OP_XOR:  alu_res = ExReadD1 ^ alu_b;
      OP_NOR:  alu_res = ~(ExReadD1 | alu_b);
      OP_SLT:  alu_res = {31'h0, $signed(ExReadD1) < $signed(alu_b)};
      OP_SLTU: alu_res = {31'h0, ExReadD1 < alu_b};
      OP_MUL, OP_DIVU, OP_REMU: alu_res = 32'h0;
      OP_SLL:  alu_res = ExReadD1 << alu_b[4:0];
      OP_SRL:  alu_res = ExReadD1 >> alu_b[4:0];
      OP_SRA:  alu_res = $signed(ExReadD1) >>> alu_b[4:0];
      default: alu_res = 32'h0;
    endcase
  end

`ifdef EX_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits (no borrow out of bit 32).
  // A zero divisor always "fits", which naturally yields an all-ones
  // quotient and leaves the dividend as the remainder.
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  always_comb begin
    div_trial = {acc, op_a[31]};
    div_diff  = div_trial - {1'b0, op_b};
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      acc       <= 32'h0;
      hold_wb   <= 4'h0;
      hold_m    <= 2'h0;
      hold_wd   <= 32'h0;
      hold_dst  <= 5'h0;
      hold_quot <= 1'b0;
      MemWb     <= 4'h0;
      MemM      <= 2'h0;
      MemAluRes <= 32'h0;
      MemWriteD <= 32'h0;
      MemDst    <= 5'h0;
      MemValid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a      <= ExReadD1;
            op_b      <= alu_b;
            acc       <= 32'h0;
            cnt       <= 5'd0;
            hold_wb   <= ExWb;
            hold_m    <= ExM;
            hold_wd   <= ExReadD2;
            hold_dst  <= dst_sel;
            hold_quot <= (alu_op == OP_DIVU);
            MemValid  <= 1'b0;
`ifdef EX_DIV_EN
            state     <= (alu_op == OP_MUL) ? MUL : DIV;
`else
            state     <= MUL;
`endif
          end else begin
            // Bubbles still write the data fields; only MemValid matters.
            MemWb     <= ExWb;
            MemM      <= ExM;
            MemAluRes <= alu_res;
            MemWriteD <= ExReadD2;
            MemDst    <= dst_sel;
            MemValid  <= ExValid;
          end
        end

        MUL: begin
          // Shift-add: consume one multiplier bit per cycle, low 32 bits kept.
          acc      <= acc + (op_b[0] ? op_a : 32'h0);
          op_a     <= op_a << 1;
          op_b     <= op_b >> 1;
          cnt      <= cnt + 5'd1;
          MemValid <= 1'b0;
          if (cnt == 5'd31) state <= DONE;
        end

`ifdef EX_DIV_EN
        DIV: begin
          if (!div_diff[32]) begin
            acc  <= div_diff[31:0];
            op_a <= {op_a[30:0], 1'b1};
          end else begin
            acc  <= div_trial[31:0];
            op_a <= {op_a[30:0], 1'b0};
          end
          cnt      <= cnt + 5'd1;
          MemValid <= 1'b0;
          if (cnt == 5'd31) state <= DONE;
        end
`endif

        DONE: begin
          MemWb     <= hold_wb;
          MemM      <= hold_m;
          MemAluRes <= hold_quot ? op_a : acc;
          MemWriteD <= hold_wd;
          MemDst    <= hold_dst;
          MemValid  <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// that same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ExValid;
  logic [3:0]  ExWb;
  logic [1:0]  ExM;
  logic [4:0]  ExEx;
  logic [31:0] ExReadD1, ExReadD2, ExAdr;
  logic [4:0]  ExRt, ExRd, ExRs;
  logic        Stall;
  logic [3:0]  MemWb;
  logic [1:0]  MemM;
  logic [31:0] MemAluRes, MemWriteD;
  logic [4:0]  MemDst;
  logic        MemValid;

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .ExValid(ExValid), .ExWb(ExWb), .ExM(ExM), .ExEx(ExEx),
    .ExReadD1(ExReadD1), .ExReadD2(ExReadD2), .ExAdr(ExAdr),
    .ExRt(ExRt), .ExRd(ExRd), .ExRs(ExRs),
    .Stall(Stall), .MemWb(MemWb), .MemM(MemM), .MemAluRes(MemAluRes),
    .MemWriteD(MemWriteD), .MemDst(MemDst), .MemValid(MemValid)
  );

  always #5 clk = ~clk;

  // Overall time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [3:0] wb, input logic [1:0] m,
                       input logic [4:0] ex, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] adr, input logic [4:0] rt, input logic [4:0] rd);
    ExValid = v; ExWb = wb; ExM = m; ExEx = ex;
    ExReadD1 = d1; ExReadD2 = d2; ExAdr = adr; ExRt = rt; ExRd = rd; ExRs = 5'd3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps a multi-cycle op (already on the inputs, Stall expected high) to
  // its result. edges counts from the accept edge inclusive to the edge that
  // delivers MemValid=1; low_ok drops if MemValid is seen high on the way.
  task automatic run_multi(output int stall_cyc, output int edges,
                           output bit low_ok, output bit timeout);
    stall_cyc = 0; edges = 0; low_ok = 1'b1; timeout = 1'b0;
    while (Stall && stall_cyc < 40) begin
      stall_cyc++;
      tick();
      edges++;
      if (MemValid) low_ok = 1'b0;
    end
    if (stall_cyc >= 40) timeout = 1'b1;
    else begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 4'hF, 2'h3, 5'h08, 32'h10001, 32'h10001, 32'h0, 5'd1, 5'd2);
    #12;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    checks++; if (MemValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", MemValid); end
    checks++; if ({MemWb, MemM, MemDst} !== 11'h0) begin failures++; $display("FAIL reset_ctl got=%h exp=0", {MemWb, MemM, MemDst}); end
    checks++; if ({MemAluRes, MemWriteD} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {MemAluRes, MemWriteD}); end
    drive(1'b0, 4'h0, 2'h0, 5'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    // ADD 0x7FFFFFFF + 1, RegDst=1 selects ExRd=5
    drive(1'b1, 4'b0100, 2'b10, 5'h00, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd9, 5'd5);
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL add_stall got=%b exp=0", Stall); end
    tick();
    checks++; if (MemAluRes !== 32'h80000000) begin failures++; $display("FAIL add_res got=%h exp=80000000", MemAluRes); end
    checks++; if (MemDst !== 5'd5) begin failures++; $display("FAIL add_dst got=%0d exp=5", MemDst); end
    checks++; if (MemValid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", MemValid); end
    checks++; if ({MemWb, MemM} !== 6'b0100_10) begin failures++; $display("FAIL add_ctl got=%b exp=010010", {MemWb, MemM}); end
    checks++; if (MemWriteD !== 32'h1) begin failures++; $display("FAIL add_wd got=%h exp=1", MemWriteD); end
  endtask

  task automatic test_slt();
    // B from immediate (ALUSrc=1), RegDst=0 selects ExRt
    drive(1'b1, 4'b0000, 2'b00, 5'h16, 32'hFFFFFFFF, 32'h1234, 32'h1, 5'd7, 5'd8);
    tick();
    checks++; if (MemAluRes !== 32'h1) begin failures++; $display("FAIL slt_res got=%h exp=1", MemAluRes); end
    checks++; if (MemDst !== 5'd7) begin failures++; $display("FAIL slt_dst got=%0d exp=7", MemDst); end
    checks++; if (MemWriteD !== 32'h1234) begin failures++; $display("FAIL slt_wd got=%h exp=1234", MemWriteD); end
    drive(1'b1, 4'b0000, 2'b00, 5'h17, 32'hFFFFFFFF, 32'h1234, 32'h1, 5'd7, 5'd8);
    tick();
    checks++; if (MemAluRes !== 32'h0) begin failures++; $display("FAIL sltu_res got=%h exp=0", MemAluRes); end
    checks++; if (MemValid !== 1'b1) begin failures++; $display("FAIL sltu_valid got=%b exp=1", MemValid); end
  endtask

  // Back-to-back single-cycle ops, one per edge, B through the immediate.
  task automatic test_alu_ops();
    logic [3:0]  op [13];
    logic [31:0] a  [13];
    logic [31:0] b  [13];
    logic [31:0] e  [13];
    op[0]  = 4'h1; a[0]  = 32'h5;         b[0]  = 32'h7;         e[0]  = 32'hFFFFFFFE;
    op[1]  = 4'h2; a[1]  = 32'hF0F01234;  b[1]  = 32'h0FF0FFFF;  e[1]  = 32'h00F01234;
    op[2]  = 4'h3; a[2]  = 32'hF0000000;  b[2]  = 32'h0000000F;  e[2]  = 32'hF000000F;
    op[3]  = 4'h4; a[3]  = 32'hFFFF0000;  b[3]  = 32'hFF00FF00;  e[3]  = 32'h00FFFF00;
    op[4]  = 4'h5; a[4]  = 32'h000000FF;  b[4]  = 32'h0000FF00;  e[4]  = 32'hFFFF0000;
    op[5]  = 4'hB; a[5]  = 32'h1;         b[5]  = 32'd31;        e[5]  = 32'h80000000;
    op[6]  = 4'hB; a[6]  = 32'h3;         b[6]  = 32'h21;        e[6]  = 32'h6;
    op[7]  = 4'hC; a[7]  = 32'h80000000;  b[7]  = 32'd4;         e[7]  = 32'h08000000;
    op[8]  = 4'hD; a[8]  = 32'h80000000;  b[8]  = 32'd4;         e[8]  = 32'hF8000000;
    op[9]  = 4'hE; a[9]  = 32'h1234;      b[9]  = 32'h5678;      e[9]  = 32'h0;
    op[10] = 4'hF; a[10] = 32'h1234;      b[10] = 32'h5678;      e[10] = 32'h0;
    op[11] = 4'h1; a[11] = 32'h0;         b[11] = 32'h1;         e[11] = 32'hFFFFFFFF;
    op[12] = 4'h0; a[12] = 32'hFFFFFFFF;  b[12] = 32'h2;         e[12] = 32'h1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 4'b0000, 2'b01, {1'b1, op[i]}, a[i], 32'hA5A5_0000 + i, b[i], 5'd4, 5'd6);
      tick();
      checks++;
      if (MemAluRes !== e[i] || MemValid !== 1'b1) begin
        failures++;
        $display("FAIL alu_op%0d op=%h got=%h/%b exp=%h/1", i, op[i], MemAluRes, MemValid, e[i]);
      end
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 4'b0100, 2'b00, 5'h08, 32'h3, 32'h5, 32'h0, 5'd1, 5'd2);
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL bubble_stall got=%b exp=0", Stall); end
    tick();
    checks++; if (MemValid !== 1'b0 || Stall !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%b/%b exp=0/0", MemValid, Stall); end
  endtask

  task automatic test_mul();
    int  sc, ed;
    bit  lo, to;
    drive(1'b1, 4'b0101, 2'b11, 5'h08, 32'h10001, 32'h10001, 32'h0, 5'd11, 5'd12);
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL mul_accept_stall got=%b exp=1", Stall); end
    run_multi(sc, ed, lo, to);
    checks++; if (to) begin failures++; $display("FAIL mul_timeout stall cycles=%0d limit=40", sc); end
    checks++; if (sc !== 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", sc); end
    checks++; if (ed !== 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", ed); end
    checks++; if (!lo) begin failures++; $display("FAIL mul_bubbles got=valid_seen exp=valid_low"); end
    checks++; if (MemValid !== 1'b1) begin failures++; $display("FAIL mul_valid got=%b exp=1", MemValid); end
    checks++; if (MemAluRes !== 32'h00020001) begin failures++; $display("FAIL mul_res got=%h exp=00020001", MemAluRes); end
    checks++; if ({MemWb, MemM, MemDst} !== {4'b0101, 2'b11, 5'd12}) begin failures++; $display("FAIL mul_ctl got=%h exp=%h", {MemWb, MemM, MemDst}, {4'b0101, 2'b11, 5'd12}); end
    checks++; if (MemWriteD !== 32'h10001) begin failures++; $display("FAIL mul_wd got=%h exp=10001", MemWriteD); end
  endtask

  // A new MUL arrives right after the previous result is delivered.
  task automatic test_back_to_back();
    int  sc, ed;
    bit  lo, to;
    drive(1'b1, 4'b0000, 2'b00, 5'h18, 32'd3, 32'hDEAD, 32'd5, 5'd13, 5'd14);
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL b2b_accept_stall got=%b exp=1", Stall); end
    run_multi(sc, ed, lo, to);
    checks++; if (to || sc !== 33 || ed !== 34 || !lo) begin failures++; $display("FAIL b2b_timing got=%0d/%0d/%b exp=33/34/1", sc, ed, lo); end
    checks++; if (MemAluRes !== 32'd15 || MemValid !== 1'b1) begin failures++; $display("FAIL b2b_res got=%h/%b exp=0000000f/1", MemAluRes, MemValid); end
    checks++; if (MemDst !== 5'd13 || MemWriteD !== 32'hDEAD) begin failures++; $display("FAIL b2b_fields got=%0d/%h exp=13/dead", MemDst, MemWriteD); end
  endtask

  task automatic test_reset_midway();
    bit seen;
    drive(1'b1, 4'b0100, 2'b01, 5'h08, 32'h10001, 32'h10001, 32'h0, 5'd1, 5'd2);
    tick();               // accept edge
    repeat (10) tick();   // iterations 0..9 done, iteration 10 in progress
    #2 rst = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", Stall); end
    checks++; if ({MemAluRes, MemWriteD} !== 64'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", {MemAluRes, MemWriteD}); end
    checks++; if ({MemWb, MemM, MemDst, MemValid} !== 12'h0) begin failures++; $display("FAIL midrst_ctl got=%h exp=0", {MemWb, MemM, MemDst, MemValid}); end
    ExValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MemValid || Stall) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midrst_stale got=activity exp=idle"); end
    drive(1'b1, 4'b0000, 2'b00, 5'h00, 32'd2, 32'd3, 32'h0, 5'd20, 5'd21);
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL midrst_idle_stall got=%b exp=0", Stall); end
    tick();
    checks++; if (MemAluRes !== 32'd5 || MemValid !== 1'b1 || MemDst !== 5'd20) begin failures++; $display("FAIL midrst_add got=%h/%b/%0d exp=5/1/20", MemAluRes, MemValid, MemDst); end
  endtask

`ifdef EX_DIV_EN
  task automatic test_div();
    logic [3:0]  op [4];
    logic [31:0] a  [4];
    logic [31:0] b  [4];
    logic [31:0] e  [4];
    int  sc, ed;
    bit  lo, to;
    op[0] = 4'h9; a[0] = 32'd100; b[0] = 32'd7; e[0] = 32'd14;
    op[1] = 4'hA; a[1] = 32'd100; b[1] = 32'd7; e[1] = 32'd2;
    op[2] = 4'h9; a[2] = 32'd5;   b[2] = 32'd0; e[2] = 32'hFFFFFFFF;
    op[3] = 4'hA; a[3] = 32'd5;   b[3] = 32'd0; e[3] = 32'd5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0000, 2'b00, {1'b0, op[i]}, a[i], b[i], 32'h0, 5'd9, 5'd10);
      #1;
      run_multi(sc, ed, lo, to);
      checks++;
      if (to || sc !== 33 || ed !== 34 || !lo) begin
        failures++; $display("FAIL div%0d_timing got=%0d/%0d/%b exp=33/34/1", i, sc, ed, lo);
      end
      checks++;
      if (MemAluRes !== e[i] || MemValid !== 1'b1) begin
        failures++; $display("FAIL div%0d_res got=%h/%b exp=%h/1", i, MemAluRes, MemValid, e[i]);
      end
    end
  endtask
`else
  task automatic test_nodiv();
    bit stalled = 1'b0;
    for (int i = 0; i < 2; i++) begin
      // Prime EX/MEM with a nonzero result so a zero result is meaningful.
      drive(1'b1, 4'b0000, 2'b00, 5'h00, 32'd1, 32'd1, 32'h0, 5'd9, 5'd10);
      tick();
      drive(1'b1, 4'b0000, 2'b00, (i == 0) ? 5'h09 : 5'h0A, 32'd100, 32'd7, 32'h0, 5'd9, 5'd10);
      #1;
      if (Stall) stalled = 1'b1;
      tick();
      if (Stall) stalled = 1'b1;
      checks++;
      if (MemAluRes !== 32'h0 || MemValid !== 1'b1) begin
        failures++; $display("FAIL nodiv%0d_res got=%h/%b exp=0/1", i, MemAluRes, MemValid);
      end
    end
    checks++; if (stalled) begin failures++; $display("FAIL nodiv_stall got=1 exp=0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_slt();
    test_alu_ops();
    test_bubble();
    test_mul();
    test_back_to_back();
    test_reset_midway();
`ifdef EX_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
